pipe_stage_buf: RTL and testbench

- Parametrised pipeline stage: DIR/ack upstream handshake, DOR/ack downstream handshake.
- Transforms each accepted word (add constant or pass-through) and holds it in an internal FIFO of DEPTH entries, so upstream is not stalled by a slow downstream.
- Drops into any position of the example pipeline chain (stage_A -> stage -> stage_C) with the same handshake signal names.

---
 rtl/pipe_stage_buf.sv | 104 ++++++++++
 tb/tb_pipe_stage_buf.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage with DIR/ack handshakes on both sides and a small FIFO.
// Accepted words are optionally incremented and buffered until consumed.
module pipe_stage_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 0,
  parameter int INC   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         DIR,
  input  logic [WIDTH-1:0]             data_in,
  output logic                         ack_prev,
  output logic                         DOR,
  output logic [WIDTH-1:0]             data_out,
  input  logic                         ack_from_next,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             ack_q;

  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] xf;

  // Word transform: wrap-around add, or straight pass-through.
  always_comb begin
    xf = data_in;
    if (MODE == 0) begin
      xf = data_in + INC_W;
    end
  end

  // Handshake qualifiers; the ack cycle itself never accepts.
  always_comb begin
    accept = DIR && !ack_q && (cnt != LVL_MAX) && !flush;
    pop    = (cnt != '0) && ack_from_next && !flush;
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem[wr_ptr] <= xf;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy counter; simultaneous accept and pop cancel out.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // One-cycle acknowledge pulse back to the producer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= accept;
    end
  end

  // Registered status and the gated head word.
  always_comb begin
    ack_prev = ack_q;
    level    = cnt;
    full     = (cnt == LVL_MAX);
    DOR      = (cnt != '0);
    data_out = DOR ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: two instances (add-one and pass-through)
// share stimulus and are checked against a queue-based model.
module tb_pipe_stage_buf;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] din = 8'd0;
  logic       ackn = 1'b0;

  logic       ack0, dor0, full0;
  logic [7:0] dout0;
  logic [2:0] lvl0;
  logic       ack1, dor1, full1;
  logic [7:0] dout1;
  logic [2:0] lvl1;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  bit         ack_m = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(8), .DEPTH(4), .MODE(0), .INC(1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .DIR(dir),
    .data_in(din), .ack_prev(ack0), .DOR(dor0), .data_out(dout0),
    .ack_from_next(ackn), .level(lvl0), .full(full0)
  );

  pipe_stage_buf #(.WIDTH(8), .DEPTH(4), .MODE(1), .INC(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .DIR(dir),
    .data_in(din), .ack_prev(ack1), .DOR(dor1), .data_out(dout1),
    .ack_from_next(ackn), .level(lvl1), .full(full1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the
  // edge, then compare both instances a little after it.
  task automatic tick();
    bit acc, pp;
    logic [7:0] e0, e1;
    if (reset || flush) begin
      q.delete();
      ack_m = 1'b0;
    end else begin
      acc = dir && !ack_m && (q.size() < 4);
      pp  = ackn && (q.size() > 0);
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(din);
      ack_m = acc;
    end
    @(posedge clk);
    #1;
    e0 = 8'd0;
    e1 = 8'd0;
    if (q.size() > 0) begin
      e1 = q[0];
      e0 = q[0] + 8'd1;
    end
    chk("ack0",  {31'd0, ack0},  {31'd0, ack_m});
    chk("dor0",  {31'd0, dor0},  {31'd0, q.size() > 0});
    chk("dout0", {24'd0, dout0}, {24'd0, e0});
    chk("lvl0",  {29'd0, lvl0},  q.size());
    chk("full0", {31'd0, full0}, {31'd0, q.size() == 4});
    chk("ack1",  {31'd0, ack1},  {31'd0, ack_m});
    chk("dor1",  {31'd0, dor1},  {31'd0, q.size() > 0});
    chk("dout1", {24'd0, dout1}, {24'd0, e1});
    chk("lvl1",  {29'd0, lvl1},  q.size());
    chk("full1", {31'd0, full1}, {31'd0, q.size() == 4});
  endtask

  // Offer one word and hold it until acknowledged (bounded wait).
  task automatic push(input logic [7:0] v);
    bit got;
    got = 1'b0;
    dir = 1'b1;
    din = v;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack_m) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL push_timeout: word %0d never acknowledged", v);
    end
    dir = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         fl;
    bit         d;
    logic [7:0] di;
    bit         an;
    bit         e_ack;
    bit         e_dor;
    logic [7:0] e_d0;
    logic [7:0] e_d1;
    int         e_lvl;
    bit         e_full;
  } vec_t;

  vec_t tv[6];

  initial begin
    tv[0] = '{1, 0, 0, 8'd0,   0, 0, 0, 8'd0, 8'd0,   0, 0};
    tv[1] = '{0, 0, 1, 8'd5,   0, 1, 1, 8'd6, 8'd5,   1, 0};
    tv[2] = '{0, 0, 0, 8'd5,   0, 0, 1, 8'd6, 8'd5,   1, 0};
    tv[3] = '{0, 0, 0, 8'd0,   1, 0, 0, 8'd0, 8'd0,   0, 0};
    tv[4] = '{0, 0, 1, 8'd255, 0, 1, 1, 8'd0, 8'd255, 1, 0};
    tv[5] = '{0, 0, 0, 8'd0,   1, 0, 0, 8'd0, 8'd0,   0, 0};

    // Table vectors: single word and wrap arithmetic.
    for (int i = 0; i < 6; i++) begin
      reset = tv[i].rst;
      flush = tv[i].fl;
      dir   = tv[i].d;
      din   = tv[i].di;
      ackn  = tv[i].an;
      tick();
      chk("tv_ack",  {31'd0, ack0},  {31'd0, tv[i].e_ack});
      chk("tv_dor",  {31'd0, dor0},  {31'd0, tv[i].e_dor});
      chk("tv_d0",   {24'd0, dout0}, {24'd0, tv[i].e_d0});
      chk("tv_d1",   {24'd0, dout1}, {24'd0, tv[i].e_d1});
      chk("tv_lvl",  {29'd0, lvl0},  tv[i].e_lvl);
      chk("tv_full", {31'd0, full0}, {31'd0, tv[i].e_full});
    end
    reset = 1'b0;
    dir = 1'b0;
    ackn = 1'b0;

    // Fill to full with downstream stalled.
    push(8'd10);
    push(8'd11);
    push(8'd12);
    push(8'd13);
    tick();
    chk("fill_full", {31'd0, full0}, 32'd1);
    chk("fill_lvl",  {29'd0, lvl0},  32'd4);
    dir = 1'b1;
    din = 8'd14;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_noack", {31'd0, ack0}, 32'd0);
    end
    // Pop with the fifth word pending: no bypass on this edge.
    ackn = 1'b1;
    tick();
    ackn = 1'b0;
    chk("nobypass_ack", {31'd0, ack0},  32'd0);
    chk("pop_head",     {24'd0, dout0}, 32'd12);
    chk("pop_lvl",      {29'd0, lvl0},  32'd3);
    tick();
    chk("late_ack", {31'd0, ack0}, 32'd1);
    chk("late_lvl", {29'd0, lvl0}, 32'd4);
    dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", {24'd0, dout0}, 32'd12 + i);
      ackn = 1'b1;
      tick();
    end
    ackn = 1'b0;
    chk("drain_empty", {31'd0, dor0}, 32'd0);

    // Simultaneous push and pop at level 2.
    push(8'd40);
    push(8'd41);
    tick();
    dir = 1'b1;
    din = 8'd42;
    ackn = 1'b1;
    tick();
    chk("simul_ack", {31'd0, ack0}, 32'd1);
    chk("simul_lvl", {29'd0, lvl0}, 32'd2);
    chk("simul_hd",  {24'd0, dout0}, 32'd42);
    dir = 1'b0;
    ackn = 1'b0;

    // Flush with level 3, DIR and ack_from_next asserted.
    push(8'd50);
    tick();
    dir = 1'b1;
    din = 8'd60;
    ackn = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush_lvl", {29'd0, lvl0}, 32'd0);
    chk("flush_dor", {31'd0, dor0}, 32'd0);
    chk("flush_ack", {31'd0, ack0}, 32'd0);
    flush = 1'b0;
    ackn = 1'b0;
    tick();
    chk("post_flush_ack", {31'd0, ack0},  32'd1);
    chk("post_flush_d",   {24'd0, dout0}, 32'd61);
    dir = 1'b0;
    tick();

    // Reset while level 2 and ack_prev high.
    push(8'd70);
    chk("pre_rst_ack", {31'd0, ack0}, 32'd1);
    chk("pre_rst_lvl", {29'd0, lvl0}, 32'd2);
    reset = 1'b1;
    dir = 1'b1;
    ackn = 1'b1;
    tick();
    chk("rst_lvl", {29'd0, lvl0},  32'd0);
    chk("rst_dor", {31'd0, dor0},  32'd0);
    chk("rst_d",   {24'd0, dout0}, 32'd0);
    reset = 1'b0;
    ackn = 1'b0;
    push(8'd7);
    chk("rst_push7", {24'd0, dout0}, 32'd8);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      dir   = ($urandom_range(0, 2) != 0);
      din   = 8'($urandom);
      ackn  = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 120) == 0);
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
